// File: rtl/cla_pkg.sv
// Shared definitions for the adder checker datapath.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cla_pkg;

  // Scoreboard state encoding, also driven straight onto the state output.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FAILED = 2'd2
  } state_t;

  // Increment that sticks at max; callers cast to their counter width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
    return (v >= max) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// In-order FIFO with show-ahead read data (dout is always the head entry).
// Latency: a pushed entry is visible on dout the cycle after the push edge when empty.
// Backpressure: none internally; the caller only asserts push/pop when legal.
module sync_fifo #(
  parameter int w     = 8,
  parameter int depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [w-1:0]           din,
  output logic [w-1:0]           dout,
  output logic [$clog2(depth):0] level
);

  localparam int aw    = $clog2(depth);
  localparam int lvl_w = aw + 1;

  logic [w-1:0]  mem [depth];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;

  // Storage has no reset; validity is tracked by level alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because depth is a power of two; level tells full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
      if (push && !pop)      level <= level + lvl_w'(1);
      else if (pop && !push) level <= level - lvl_w'(1);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/adder_scoreboard.sv
// Checks adder results against a locally computed reference sum queued in order.
// Latency: all outputs registered, updating at the edge that samples the cause.
// Backpressure: none; pushes into a full FIFO without a pop are dropped and flagged.
module adder_scoreboard
  import cla_pkg::*;
#(
  parameter int w     = 128,
  parameter int depth = 8,
  parameter int cnt_w = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [w-1:0]           in_op1,
  input  logic [w-1:0]           in_op2,
  input  logic                   in_cin,
  input  logic                   res_valid,
  input  logic [w-1:0]           res,
  output logic                   error,
  output logic                   overflow,
  output logic                   underflow,
  output logic [1:0]             state,
  output logic [cnt_w-1:0]       check_cnt,
  output logic [cnt_w-1:0]       mismatch_cnt,
  output logic [cnt_w-1:0]       fail_idx,
  output logic [w-1:0]           fail_exp,
  output logic [w-1:0]           fail_got,
  output logic [$clog2(depth):0] level
);

  localparam int               lvl_w   = $clog2(depth) + 1;
  localparam logic [cnt_w-1:0] cnt_max = '1;

  logic [w-1:0]     exp_sum;
  logic [w-1:0]     head;
  logic [lvl_w-1:0] fifo_level;
  logic             fifo_empty;
  logic             fifo_full;
  logic             do_pop;
  logic             do_push;
  logic             mismatch;
  state_t           state_q;
  state_t           state_d;

  // Reference sum; carry-out is intentionally dropped by the w-bit result.
  assign exp_sum    = in_op1 + in_op2 + w'(in_cin);
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == lvl_w'(depth));
  assign do_pop     = res_valid && !fifo_empty;
  // A pop in the same cycle frees the slot, so push+pop at full is accepted.
  assign do_push    = in_valid && (!fifo_full || do_pop);
  assign mismatch   = do_pop && (head != res);

  sync_fifo #(
    .w     (w),
    .depth (depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .pop   (do_pop),
    .din   (exp_sum),
    .dout  (head),
    .level (fifo_level)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: start on first accepted push, latch FAILED on first mismatch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (do_push)  state_d = ST_RUN;
      ST_RUN:    if (mismatch) state_d = ST_FAILED;
      ST_FAILED: state_d = ST_FAILED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Sticky flags, saturating counters and the first-failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      error        <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      check_cnt    <= '0;
      mismatch_cnt <= '0;
      fail_idx     <= '0;
      fail_exp     <= '0;
      fail_got     <= '0;
    end else begin
      if (in_valid && !do_push)      overflow  <= 1'b1;
      if (res_valid && fifo_empty)   underflow <= 1'b1;
      if (do_pop) check_cnt <= cnt_w'(sat_inc(64'(check_cnt), 64'(cnt_max)));
      if (mismatch) begin
        error        <= 1'b1;
        mismatch_cnt <= cnt_w'(sat_inc(64'(mismatch_cnt), 64'(cnt_max)));
      end
      // fail_idx takes the pre-increment count, i.e. the 0-based compare index.
      if (mismatch && state_q == ST_RUN) begin
        fail_idx <= check_cnt;
        fail_exp <= head;
        fail_got <= res;
      end
    end
  end

  assign state = state_q;
  assign level = fifo_level;

endmodule

// File: tb/tb_adder_scoreboard.sv
module tb_adder_scoreboard;

  localparam int W = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_op1 = '0;
  logic [W-1:0]  in_op2 = '0;
  logic          in_cin = 1'b0;
  logic          res_valid = 1'b0;
  logic [W-1:0]  res = '0;
  logic          error, overflow, underflow;
  logic [1:0]    state;
  logic [15:0]   check_cnt, mismatch_cnt, fail_idx;
  logic [W-1:0]  fail_exp, fail_got;
  logic [3:0]    level;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench model of the scoreboard, derived from operands the bench drives.
  logic [W-1:0] q[$];
  logic [15:0]  m_chk, m_mis, m_fidx;
  logic [W-1:0] m_fexp, m_fgot;
  logic         m_err, m_ovf, m_unf;
  logic [1:0]   m_state;

  adder_scoreboard #(.w(W), .depth(8), .cnt_w(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op1(in_op1), .in_op2(in_op2),
    .in_cin(in_cin), .res_valid(res_valid), .res(res), .error(error),
    .overflow(overflow), .underflow(underflow), .state(state),
    .check_cnt(check_cnt), .mismatch_cnt(mismatch_cnt), .fail_idx(fail_idx),
    .fail_exp(fail_exp), .fail_got(fail_got), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] good();
    return (q.size() > 0) ? q[0] : '0;
  endfunction

  task automatic clear_model();
    q.delete();
    m_chk = '0; m_mis = '0; m_fidx = '0; m_fexp = '0; m_fgot = '0;
    m_err = 0; m_ovf = 0; m_unf = 0; m_state = 2'd0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".error"},    W'(error),        W'(m_err));
    check({tag, ".ovf"},      W'(overflow),     W'(m_ovf));
    check({tag, ".unf"},      W'(underflow),    W'(m_unf));
    check({tag, ".state"},    W'(state),        W'(m_state));
    check({tag, ".chk_cnt"},  W'(check_cnt),    W'(m_chk));
    check({tag, ".mis_cnt"},  W'(mismatch_cnt), W'(m_mis));
    check({tag, ".fidx"},     W'(fail_idx),     W'(m_fidx));
    check({tag, ".fexp"},     fail_exp,         m_fexp);
    check({tag, ".fgot"},     fail_got,         m_fgot);
    check({tag, ".level"},    W'(level),        W'(q.size()));
  endtask

  // One clock: drive inputs, advance past the edge, update model, optionally compare.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic rv, input logic [W-1:0] r,
                      input bit chk, input string tag);
    logic [W-1:0] s, e;
    bit pop, push_ok;
    in_valid = v; in_op1 = a; in_op2 = b; in_cin = c;
    res_valid = rv; res = r;
    @(posedge clk); #1;
    s = a + b + W'(c);
    pop = rv && (q.size() > 0);
    push_ok = v && (q.size() < 8 || pop);
    if (rv && q.size() == 0) m_unf = 1;
    if (v && !push_ok) m_ovf = 1;
    if (pop) begin
      e = q.pop_front();
      if (e != r) begin
        m_err = 1;
        if (m_mis != 16'hFFFF) m_mis++;
        if (m_state == 2'd1) begin
          m_fidx = m_chk; m_fexp = e; m_fgot = r; m_state = 2'd2;
        end
      end
      if (m_chk != 16'hFFFF) m_chk++;
    end
    if (push_ok) begin
      q.push_back(s);
      if (m_state == 2'd0) m_state = 2'd1;
    end
    in_valid = 0; res_valid = 0;
    if (chk) check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0, 1, "idle");
  endtask

  // Reset for one edge; optionally present traffic that must be ignored.
  task automatic do_reset(input bit with_traffic);
    rst = 1; in_valid = with_traffic; res_valid = with_traffic;
    in_op1 = 128'h3; in_op2 = 128'h4; res = 128'h99;
    @(posedge clk); #1;
    rst = 0; in_valid = 0; res_valid = 0;
    clear_model();
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".error"},   W'(error),        '0);
    check({tag, ".ovf"},     W'(overflow),     '0);
    check({tag, ".unf"},     W'(underflow),    '0);
    check({tag, ".state"},   W'(state),        '0);
    check({tag, ".chk_cnt"}, W'(check_cnt),    '0);
    check({tag, ".mis_cnt"}, W'(mismatch_cnt), '0);
    check({tag, ".fidx"},    W'(fail_idx),     '0);
    check({tag, ".fexp"},    fail_exp,         '0);
    check({tag, ".fgot"},    fail_got,         '0);
    check({tag, ".level"},   W'(level),        '0);
  endtask

  initial begin
    logic [W-1:0] ones;
    ones = '1;
    clear_model();
    @(posedge clk); #1;
    do_reset(0);
    check_zero("rst0");

    // Basic: 5 + A + 1 = 0x10, result four cycles later.
    step(1, 128'h5, 128'hA, 1, 0, '0, 1, "t1_push");
    idle(3);
    step(0, '0, '0, 0, 1, 128'h10, 1, "t1_pop");
    check("t1.chk", W'(check_cnt), 128'd1);
    check("t1.err", W'(error), 128'd0);
    check("t1.state", W'(state), 128'd1);
    check("t1.level", W'(level), 128'd0);

    // Carry-out dropped: all-ones + 0 + 1 wraps to 0.
    step(1, ones, '0, 1, 0, '0, 1, "wrap_push");
    step(0, '0, '0, 0, 1, 128'h0, 1, "wrap_pop");
    check("wrap.err", W'(error), 128'd0);

    // Three good, one mismatch (exp 0, got 1), two more mismatches.
    do_reset(0);
    for (int i = 0; i < 3; i++) begin
      step(1, rnd(), rnd(), 1'($urandom), 0, '0, 1, "mm_push");
      step(0, '0, '0, 0, 1, good(), 1, "mm_pop");
    end
    step(1, '0, '0, 0, 0, '0, 1, "mm_push0");
    step(0, '0, '0, 0, 1, 128'h1, 1, "mm_bad");
    for (int i = 0; i < 2; i++) begin
      step(1, rnd(), rnd(), 1'($urandom), 0, '0, 1, "mm_push2");
      step(0, '0, '0, 0, 1, good() ^ 128'h2, 1, "mm_bad2");
    end
    check("mm.err", W'(error), 128'd1);
    check("mm.state", W'(state), 128'd2);
    check("mm.fidx", W'(fail_idx), 128'd3);
    check("mm.fexp", fail_exp, 128'd0);
    check("mm.fgot", fail_got, 128'd1);
    check("mm.mis_cnt", W'(mismatch_cnt), 128'd3);
    check("mm.chk_cnt", W'(check_cnt), 128'd6);

    // Nine pushes without pops: ninth dropped.
    do_reset(0);
    for (int i = 0; i < 9; i++) step(1, rnd(), rnd(), 0, 0, '0, 1, "ovf_push");
    check("ovf.flag", W'(overflow), 128'd1);
    check("ovf.level", W'(level), 128'd8);

    // Full, then push+pop together: accepted, level stays 8, no overflow.
    do_reset(0);
    for (int i = 0; i < 8; i++) step(1, rnd(), rnd(), 1, 0, '0, 1, "full_push");
    step(1, rnd(), rnd(), 1, 1, good(), 1, "full_pp");
    check("full.ovf", W'(overflow), 128'd0);
    check("full.level", W'(level), 128'd8);
    for (int i = 0; i < 8; i++) step(0, '0, '0, 0, 1, good(), 1, "full_drain");
    check("full.err", W'(error), 128'd0);
    check("full.chk", W'(check_cnt), 128'd9);

    // res_valid on empty FIFO with the first push: underflow, entry still stored.
    do_reset(0);
    step(1, 128'h7, 128'h8, 0, 1, 128'hF, 1, "unf_both");
    check("unf.flag", W'(underflow), 128'd1);
    check("unf.level", W'(level), 128'd1);
    check("unf.chk", W'(check_cnt), 128'd0);
    step(0, '0, '0, 0, 1, 128'hF, 1, "unf_next");
    check("unf.chk2", W'(check_cnt), 128'd1);
    check("unf.err", W'(error), 128'd0);

    // Reset from FAILED with level 5; traffic during the reset edge is ignored.
    do_reset(0);
    step(1, '0, '0, 0, 0, '0, 1, "rf_push");
    step(0, '0, '0, 0, 1, 128'h5, 1, "rf_bad");
    for (int i = 0; i < 5; i++) step(1, rnd(), rnd(), 0, 0, '0, 1, "rf_fill");
    check("rf.state", W'(state), 128'd2);
    check("rf.level", W'(level), 128'd5);
    do_reset(1);
    check_zero("rf_after");

    // Saturation: 2^16 compares, check_cnt holds at 0xFFFF.
    step(1, 128'h1, 128'h2, 0, 0, '0, 1, "sat_first");
    for (int i = 0; i < 65536; i++)
      step(1, W'(i), W'(3 * i), 1'(i), 1, good(), 0, "sat");
    check_all("sat_end");
    check("sat.chk", W'(check_cnt), 128'hFFFF);
    check("sat.err", W'(error), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_scoreboard.md
# adder_scoreboard

Self-checking result scoreboard placed directly downstream of `pipelined_adder` in the adder checker datapath. It taps the operand stream entering the adder and computes the reference sum. It queues that sum in an in-order FIFO, pops one entry per `valid` from the adder, and compares. It reports a sticky error, saturating statistics and a frozen capture of the first failing transaction for ILA/LED readout, independent of the adder's pipeline depth.

## Interface
Parameters:
- `w`, 128, operand/result width
- `depth`, 8, expected-value FIFO entries; power of two, ≥ adder latency + 1
- `cnt_w`, 16, width of all counters

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operands below are presented to the adder this cycle
- `in_op1`  in  w  adder operand 1
- `in_op2`  in  w  adder operand 2
- `in_cin`  in  1  adder carry-in
- `res_valid`  in  1  adder `valid`
- `res`  in  w  adder `res`
- `error`  out  1  sticky: at least one mismatch
- `overflow`  out  1  sticky: push attempted while FIFO full and no pop
- `underflow`  out  1  sticky: `res_valid` while FIFO empty
- `state`  out  2  0=IDLE, 1=RUN, 2=FAILED
- `check_cnt`  out  cnt_w  compared results, saturating
- `mismatch_cnt`  out  cnt_w  mismatches, saturating
- `fail_idx`  out  cnt_w  `check_cnt` value (0-based) of first mismatch
- `fail_exp`  out  w  expected sum of first mismatch
- `fail_got`  out  w  `res` of first mismatch
- `level`  out  $clog2(depth)+1  FIFO occupancy

## Operation
- Reset (`rst`=1 at an edge): all outputs 0, FIFO pointers 0, `state`=IDLE. Reset mid-operation discards queued entries; a `res_valid` in the reset cycle is ignored.
- Push: when `in_valid`, store `exp = (in_op1 + in_op2 + in_cin) mod 2^w`, i.e. carry-out dropped.
- A push when `level==depth` and no pop in that cycle is dropped and sets `overflow`.
- Pop/compare: when `res_valid` and `level>0`, pop the head and compare it with `res`.
  - `check_cnt` increments, saturating at 2^cnt_w−1.
  - On inequality, `mismatch_cnt` increments (saturating) and `error` sets.
- When `res_valid` and `level==0`: `underflow` sets, no compare, counters unchanged. No same-cycle bypass: a push in that cycle is still stored.
- Simultaneous push and pop is legal at any level, including full; `level` is unchanged.
- FIFO pointers wrap modulo `depth`; `level` distinguishes full from empty.
- State machine:
  - IDLE→RUN on the first accepted push.
  - RUN→FAILED on the first mismatch. In that cycle `fail_idx`, `fail_exp` and `fail_got` are loaded.
  - FAILED holds until reset. Comparisons and counters continue; capture registers stay frozen.
  - `res_valid` in IDLE with an empty FIFO only sets `underflow`.
- `overflow` and `underflow` do not change `state`.

## Timing
- Every output is registered and updates at the edge that samples the causing input. For example, a mismatching `res_valid` at edge N gives `error`=1, `state`=FAILED and the captures valid after edge N.
- Push-to-compare latency is set entirely by the adder. The FIFO adds no constraint beyond `depth`.
- The reference-sum adder is a full-width combinational add before the FIFO write. It is acceptable at checker clock rates; no pipelining is required inside this block.

## Structure
- Shared package `cla_pkg`: the state encoding constants `ST_IDLE=2'd0`, `ST_RUN=2'd1`, `ST_FAILED=2'd2`, and a saturating-increment function used for all counters.
- One sub-module: `sync_fifo` (parameters `w`, `depth`) with ports `push`, `pop`, `din`, `dout`, `level`, and show-ahead `dout`. Scoreboard logic (reference add, compare, counters, FSM, capture) lives in `adder_scoreboard`.

## Test plan
- Reset, then push 1 transaction op1=0x5, op2=0xA, cin=1; 4 cycles later `res_valid` with res=0x10 → `check_cnt`=1, `error`=0, `state`=RUN, `level` back to 0.
- Wrap: op1=all-ones, op2=0, cin=1, then res=0 → no error, i.e. carry-out is dropped.
- Mismatch: 3 correct transactions, then res=0x1 against expected 0x0, then 2 more mismatches → `error`=1, `state`=FAILED, `fail_idx`=3, `fail_exp`=0, `fail_got`=1, `mismatch_cnt`=3, `check_cnt`=6.
- Full boundary, `depth`=8:
  - 9 pushes with no pops → `overflow`=1, `level`=8.
  - After reset, fill to 8, then push and pop together → no overflow, `level`=8.
- `res_valid` with an empty FIFO in the same cycle as the first push → `underflow`=1, `level`=1, no compare. The next `res_valid` compares against that entry.
- Assert `rst` with `level`=5 and `state`=FAILED → all outputs 0 and `state`=IDLE on the next cycle; saturation check: force 2^16 compares with cnt_w=16 → `check_cnt` holds at 0xFFFF.
